// File: rtl/ysyx_22050598_ifu_fetch.sv
// Multi-cycle instruction fetch: one outstanding imem read, valid/ready to decode,
// execute jump redirects and trap flushes that override every other PC update.
module ysyx_22050598_ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag,
    input  logic [63:0] j_pc,
    input  logic        flush_valid,
    input  logic [63:0] flush_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [63:0] pc_now,
    output logic [31:0] id_inst,
    output logic        if_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_inst;
    logic        r_fault;
    logic        r_drop;

    state_t      w_state_nxt;
    logic [63:0] w_pc_nxt;
    logic [31:0] w_inst_nxt;
    logic        w_fault_nxt;
    logic        w_drop_nxt;

    // Redirect targets are word aligned; the low two bits are discarded on load.
    function automatic logic [63:0] align4(input logic [63:0] a);
        return a & 64'hFFFF_FFFF_FFFF_FFFC;
    endfunction

    // State, PC and held-instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= NOP_INST;
            r_fault <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_fault <= w_fault_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Next-state logic; a flush wins over every other PC source.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_fault_nxt = r_fault;
        w_drop_nxt  = r_drop;
        case (r_state)
            S_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = flush_valid;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (r_drop || flush_valid) begin
                        w_state_nxt = S_REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_inst_nxt  = imem_resp_err ? NOP_INST : imem_resp_data;
                        w_fault_nxt = imem_resp_err;
                    end
                end else if (flush_valid) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                if (flush_valid) begin
                    w_state_nxt = S_REQ;
                end else if (id_ready) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = jump_flag ? align4(j_pc) : r_pc + 64'd4;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
                w_drop_nxt  = 1'b0;
            end
        endcase
        if (flush_valid) begin
            w_pc_nxt = align4(flush_pc);
        end else begin
            w_pc_nxt = w_pc_nxt;
        end
    end

    assign imem_req_valid = (r_state == S_REQ) && rst;
    assign imem_req_addr  = r_pc;
    assign pc_now         = r_pc;
    assign if_valid       = (r_state == S_HOLD);
    assign id_inst        = (r_state == S_HOLD) ? r_inst : NOP_INST;
    assign if_fault       = (r_state == S_HOLD) && r_fault;

endmodule

// File: tb/tb_ysyx_22050598_ifu_fetch.sv
// Directed bench for the fetch stage: a transaction-level model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_ysyx_22050598_ifu_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag = 1'b0;
    logic [63:0] j_pc = 64'd0;
    logic        flush_valid = 1'b0;
    logic [63:0] flush_pc = 64'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        imem_resp_err = 1'b0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [63:0] pc_now;
    logic [31:0] id_inst;
    logic        if_fault;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    ysyx_22050598_ifu_fetch dut (
        .clk(clk), .rst(rst), .jump_flag(jump_flag), .j_pc(j_pc),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .if_valid(if_valid), .id_ready(id_ready), .pc_now(pc_now),
        .id_inst(id_inst), .if_fault(if_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request is in flight (busy), an instruction is presented (have),
    // or neither (a request is being offered).
    logic        m_busy, m_have, m_drop, m_fault;
    logic [63:0] m_pc;
    logic [31:0] m_inst;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_have = 1'b0; m_drop = 1'b0;
            m_pc = 64'h8000_0000; m_inst = NOP; m_fault = 1'b0;
        end else begin
            logic nb, nh, nd;
            logic [63:0] npc;
            nb = m_busy; nh = m_have; nd = m_drop; npc = m_pc;
            if (m_have) begin
                if (flush_valid) nh = 1'b0;
                else if (id_ready) begin
                    nh = 1'b0;
                    npc = jump_flag ? (j_pc & ~64'd3) : m_pc + 64'd4;
                end
            end else if (m_busy) begin
                if (imem_resp_valid) begin
                    nb = 1'b0;
                    if (m_drop || flush_valid) nd = 1'b0;
                    else begin
                        nh = 1'b1;
                        m_inst = imem_resp_err ? NOP : imem_resp_data;
                        m_fault = imem_resp_err;
                    end
                end else if (flush_valid) nd = 1'b1;
            end else if (imem_req_ready) begin
                nb = 1'b1;
                nd = flush_valid;
            end
            if (flush_valid) npc = flush_pc & ~64'd3;
            m_busy = nb; m_have = nh; m_drop = nd; m_pc = npc;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_valid", {63'd0, imem_req_valid}, {63'd0, rst && !m_busy && !m_have});
            chk("req_addr", imem_req_addr, m_pc);
            chk("pc_now", pc_now, m_pc);
            chk("if_valid", {63'd0, if_valid}, {63'd0, m_have});
            chk("id_inst", {32'd0, id_inst}, {32'd0, m_have ? m_inst : NOP});
            chk("if_fault", {63'd0, if_fault}, {63'd0, m_have && m_fault});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch_to_hold(input logic [31:0] data, input logic err);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = data; imem_resp_err = err;
        tick();
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    endtask

    task automatic consume(input logic jmp, input logic [63:0] tgt);
        id_ready = 1'b1; jump_flag = jmp; j_pc = tgt;
        tick();
        id_ready = 1'b0; jump_flag = 1'b0;
    endtask

    initial begin
        logic [31:0] s_inst;
        logic [63:0] s_pc;
        int ifv_cnt;
        // Reset held for 3 cycles, then release.
        tick(); cmp_en = 1'b1;
        tick(); tick();
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_pc_now", pc_now, 64'h8000_0000);
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_id_inst", {32'd0, id_inst}, 64'h13);
        rst = 1'b1;
        #1;
        chk("rel_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("rel_addr", imem_req_addr, 64'h8000_0000);
        tick();

        // Sequential fetch.
        fetch_to_hold(32'h0010_0093, 1'b0);
        chk("seq_if_valid", {63'd0, if_valid}, 64'd1);
        chk("seq_inst", {32'd0, id_inst}, 64'h0010_0093);
        chk("seq_pc", pc_now, 64'h8000_0000);
        consume(1'b0, 64'd0);
        chk("seq_if_valid_drop", {63'd0, if_valid}, 64'd0);
        chk("seq_next_addr", imem_req_addr, 64'h8000_0004);

        // Zero-wait streaming: resp_valid held high must be ignored outside WAIT.
        ifv_cnt = 0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b1; id_ready = 1'b1;
        imem_resp_data = 32'h0020_0113;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (if_valid) ifv_cnt++;
        end
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; id_ready = 1'b0;
        chk("stream_count", 64'(ifv_cnt), 64'd3);
        chk("stream_addr", imem_req_addr, 64'h8000_0010);

        // Jump with misaligned target, then a plain pc+4.
        fetch_to_hold(32'h0000_0063, 1'b0);
        consume(1'b1, 64'h8000_0102);
        chk("jump_addr", imem_req_addr, 64'h8000_0100);
        fetch_to_hold(32'h0000_0033, 1'b0);
        consume(1'b0, 64'h8000_0900);
        chk("nojump_addr", imem_req_addr, 64'h8000_0104);

        // Backpressure for 5 cycles.
        fetch_to_hold(32'h1234_5678, 1'b0);
        s_inst = id_inst; s_pc = pc_now;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_inst", {32'd0, id_inst}, {32'd0, s_inst});
            chk("bp_pc", pc_now, s_pc);
            chk("bp_req_valid", {63'd0, imem_req_valid}, 64'd0);
        end
        chk("bp_inst_lit", {32'd0, id_inst}, 64'h1234_5678);
        consume(1'b0, 64'd0);
        chk("bp_next_addr", imem_req_addr, 64'h8000_0108);

        // Flush while waiting; response arrives two cycles later and is dropped.
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        flush_valid = 1'b1; flush_pc = 64'h8000_0200; tick(); flush_valid = 1'b0;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; tick(); imem_resp_valid = 1'b0;
        chk("fw_if_valid", {63'd0, if_valid}, 64'd0);
        chk("fw_addr", imem_req_addr, 64'h8000_0200);
        fetch_to_hold(32'h0030_0193, 1'b0);
        chk("fw_inst", {32'd0, id_inst}, 64'h0030_0193);
        chk("fw_pc", pc_now, 64'h8000_0200);
        consume(1'b0, 64'd0);

        // Flush in the same cycle the request is accepted.
        imem_req_ready = 1'b1; flush_valid = 1'b1; flush_pc = 64'h8000_0303;
        tick();
        imem_req_ready = 1'b0; flush_valid = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_AAAA; tick(); imem_resp_valid = 1'b0;
        chk("fa_if_valid", {63'd0, if_valid}, 64'd0);
        chk("fa_addr", imem_req_addr, 64'h8000_0300);
        fetch_to_hold(32'h0040_0213, 1'b0);
        chk("fa_pc", pc_now, 64'h8000_0300);
        consume(1'b0, 64'd0);

        // Flush together with the response.
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555;
        flush_valid = 1'b1; flush_pc = 64'h8000_0400;
        tick();
        imem_resp_valid = 1'b0; flush_valid = 1'b0;
        chk("fr_if_valid", {63'd0, if_valid}, 64'd0);
        chk("fr_addr", imem_req_addr, 64'h8000_0400);

        // Flush in HOLD beats a same-cycle jump.
        fetch_to_hold(32'h0000_0073, 1'b0);
        flush_valid = 1'b1; flush_pc = 64'h8000_0500;
        consume(1'b1, 64'h8000_0700);
        flush_valid = 1'b0;
        chk("fh_if_valid", {63'd0, if_valid}, 64'd0);
        chk("fh_addr", imem_req_addr, 64'h8000_0500);

        // Access fault, then a clean fetch.
        fetch_to_hold(32'hFFFF_FFFF, 1'b1);
        chk("flt_fault", {63'd0, if_fault}, 64'd1);
        chk("flt_inst", {32'd0, id_inst}, 64'h13);
        chk("flt_pc", pc_now, 64'h8000_0500);
        consume(1'b0, 64'd0);
        fetch_to_hold(32'h0060_0313, 1'b0);
        chk("clean_fault", {63'd0, if_fault}, 64'd0);
        consume(1'b0, 64'd0);
        chk("clean_addr", imem_req_addr, 64'h8000_0508);

        // pc+4 wraps at the top of the address space.
        flush_valid = 1'b1; flush_pc = 64'hFFFF_FFFF_FFFF_FFFE; tick(); flush_valid = 1'b0;
        chk("wrap_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_to_hold(32'h0050_0293, 1'b0);
        consume(1'b0, 64'd0);
        chk("wrap_zero", imem_req_addr, 64'h0);

        // Reset while waiting; a late response after release is ignored.
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rw_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rw_pc", pc_now, 64'h8000_0000);
        chk("rw_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rw_inst", {32'd0, id_inst}, 64'h13);
        tick(); tick();
        rst = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h0BAD_0BAD;
        tick();
        imem_resp_valid = 1'b0;
        chk("late_if_valid", {63'd0, if_valid}, 64'd0);
        chk("late_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("late_addr", imem_req_addr, 64'h8000_0000);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22050598_ifu_fetch.md
Name:
ysyx_22050598_ifu_fetch

Overview:
Multi-cycle instruction fetch stage that sits directly upstream of decode/execute. It holds the PC and issues one instruction-memory read at a time over a valid/ready request and response interface. It presents the fetched instruction and its PC to decode with a valid/ready handshake, and it accepts jump redirects from execute and asynchronous flushes from trap logic.

Parameters:
RESET_PC, 64'h8000_0000, PC loaded on reset.
NOP_INST, 32'h0000_0013, value driven on id_inst when no instruction is valid or a fetch faults.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
jump_flag  in  1  execute redirect; sampled only on the decode handshake.
j_pc  in  64  redirect target.
flush_valid  in  1  trap/flush redirect; accepted in any state.
flush_pc  in  64  flush target.
imem_req_valid  out  1  read request valid.
imem_req_ready  in  1  memory accepts the request.
imem_req_addr  out  64  fetch address, equal to the PC register.
imem_resp_valid  in  1  read data valid.
imem_resp_data  in  32  instruction word.
imem_resp_err  in  1  access fault qualifier for the response.
if_valid  out  1  id_inst/pc_now valid to decode.
id_ready  in  1  decode/execute consumes the instruction this cycle.
pc_now  out  64  PC of the presented instruction (the PC register).
id_inst  out  32  instruction to decode.
if_fault  out  1  presented instruction carries a fetch fault.

Behaviour:
- Reset (rst=0, async): state=REQ, pc=RESET_PC, inst_q=NOP_INST, fault_q=0, drop=0. Outputs while reset is asserted: imem_req_valid=0, if_valid=0, id_inst=NOP_INST, if_fault=0.
- States are REQ, WAIT and HOLD. Exactly one request may be outstanding.
- REQ:
  - imem_req_valid=1, addr=pc.
  - valid&ready -> WAIT.
  - Addr is stable until accepted, except on a flush.
- WAIT:
  - imem_req_valid=0.
  - imem_resp_valid is used only in this state; it is ignored in REQ and HOLD.
  - On resp_valid with drop=0: inst_q<=resp_data, or NOP_INST if resp_err; fault_q<=resp_err; go to HOLD.
  - On resp_valid with drop=1: discard the data, clear drop, go to REQ.
- HOLD:
  - if_valid=1, id_inst=inst_q, if_fault=fault_q, pc_now=pc.
  - All outputs stay stable while id_ready=0; no request is issued.
  - On id_ready=1: pc<=jump_flag ? j_pc : pc+4, go to REQ.
  - Leaving HOLD takes effect at that edge; if_valid=0 from the next cycle.
- Flush: flush_valid=1 sets pc<=flush_pc at the edge, overriding every other PC update, including a same-cycle jump or pc+4.
  - In REQ, not accepted: stay REQ with the new address.
  - In REQ, accepted the same cycle: go to WAIT with drop=1.
  - In WAIT, with no resp that cycle: drop<=1.
  - In WAIT, with resp the same cycle: discard the response, go to REQ.
  - In HOLD: discard the held instruction, go to REQ, if_valid=0 next cycle.
- Redirect alignment: bits [1:0] of j_pc and flush_pc are forced to 0 when loaded.
- Arithmetic: pc+4 is 64-bit and wraps modulo 2^64.
- Latency: with zero-wait memory and id_ready=1, throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Reset mid-operation: any state returns to the reset values immediately. A response arriving after reset release is ignored because the state is REQ.
- id_inst is NOP_INST whenever if_valid=0.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> req_valid=0, pc_now=0x8000_0000, if_valid=0. Release rst -> req_valid=1 with addr 0x8000_0000 in the first cycle.
- Sequential fetch: ready=1, resp one cycle after acceptance with data 0x00100093, id_ready=1 -> if_valid for 1 cycle with id_inst=0x00100093. Next req addr is 0x8000_0004, and instructions arrive at 3-cycle spacing.
- Jump: in HOLD with id_ready=1, jump_flag=1, j_pc=0x8000_0102 -> next req addr is 0x8000_0100. Repeat with jump_flag=0 -> next req addr is pc+4.
- Backpressure: id_ready=0 for 5 cycles in HOLD -> id_inst, pc_now and if_fault stable, req_valid=0 throughout.
- Flush in WAIT: flush_pc=0x8000_0200, response 0xDEADBEEF arrives 2 cycles later -> no if_valid. Next req addr is 0x8000_0200 and the following instruction is delivered normally.
- Flush races and fault:
  - Flush asserted in the same cycle the request is accepted -> the stale response is dropped and the refetch goes to flush_pc.
  - resp_err=1 -> HOLD with if_fault=1, id_inst=0x0000_0013.
  - rst asserted in WAIT -> outputs return to reset values within the same cycle.
